// File: rtl/stage_execute_mc.sv
// -----------------------------------------------------------------------------
// stage_execute_mc
// Multi-cycle execute stage. Single-cycle ALU ops, branches and jumps resolve
// in one cycle. R-type mul/div run on an iterative shift-add / restoring-divide
// engine for WIDTH cycles. Both sides use valid/ready handshakes, and all
// result outputs are registered.
//
// Ports:
//   clock, reset_n            rising-edge clock, async active-low reset
//   in_valid / in_ready       decode-side handshake (in_ready is combinational)
//   opcode, alu_op, shamt     instruction fields
//   immediate, target, rd_in  I-type immediate, J-type target, dest tag
//   op_a, op_b, pc_plus_4     operands and next sequential PC
//   flush                     synchronous kill of the in-flight instruction
//   out_valid / out_ready     memory-side handshake
//   o_out, b_out, rd_out      result, store data, dest tag
//   take_branch, pc_next      fetch redirect
//   overflow, div_by_zero     exception flags
// -----------------------------------------------------------------------------
module stage_execute_mc #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [4:0]       opcode,
    input  logic [4:0]       alu_op,
    input  logic [4:0]       shamt,
    input  logic [16:0]      immediate,
    input  logic [26:0]      target,
    input  logic [4:0]       rd_in,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic [WIDTH-1:0] pc_plus_4,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] o_out,
    output logic [WIDTH-1:0] b_out,
    output logic [4:0]       rd_out,
    output logic             take_branch,
    output logic [WIDTH-1:0] pc_next,
    output logic             overflow,
    output logic             div_by_zero
);
    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    localparam logic [4:0] OP_RTYPE = 5'b00000;
    localparam logic [4:0] OP_J     = 5'b00001;
    localparam logic [4:0] OP_BNE   = 5'b00010;
    localparam logic [4:0] OP_JAL   = 5'b00011;
    localparam logic [4:0] OP_JR    = 5'b00100;
    localparam logic [4:0] OP_ADDI  = 5'b00101;
    localparam logic [4:0] OP_BLT   = 5'b00110;
    localparam logic [4:0] OP_SW    = 5'b00111;
    localparam logic [4:0] OP_LW    = 5'b01000;
    localparam logic [4:0] OP_BEX   = 5'b10110;

    localparam logic [4:0] ALU_ADD = 5'b00000;
    localparam logic [4:0] ALU_SUB = 5'b00001;
    localparam logic [4:0] ALU_AND = 5'b00010;
    localparam logic [4:0] ALU_OR  = 5'b00011;
    localparam logic [4:0] ALU_SLL = 5'b00100;
    localparam logic [4:0] ALU_SRA = 5'b00101;
    localparam logic [4:0] ALU_MUL = 5'b00110;
    localparam logic [4:0] ALU_DIV = 5'b00111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_BUSY = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    state_t             r_state, w_state_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_is_div, r_neg, r_b_zero;
    logic [WIDTH-1:0]   r_mag_m;      // multiplicand or divisor magnitude
    logic [WIDTH:0]     r_hi;         // product high half / partial remainder
    logic [WIDTH-1:0]   r_lo;         // multiplier bits / dividend-quotient
    logic               r_out_valid, r_take, r_ovf, r_dbz;
    logic [WIDTH-1:0]   r_o_out, r_b_out, r_pc_next;
    logic [4:0]         r_rd_out;

    logic               w_accept, w_use_imm, w_is_multi, w_ovf_en, w_last;
    logic [WIDTH-1:0]   w_imm_sext, w_opb, w_sum, w_diff, w_alu, w_mag_a, w_mag_b;
    logic [4:0]         w_eff_op;
    logic               w_ovf, w_take;
    logic [WIDTH-1:0]   w_pc, w_btgt, w_jtgt;
    logic [WIDTH:0]     w_madd, w_shift, w_hi_nxt;
    logic [WIDTH+1:0]   w_trial;
    logic [WIDTH-1:0]   w_lo_nxt, w_quo;
    logic [2*WIDTH-1:0] w_prod_mag, w_prod;
    logic               w_mul_ovf;

    assign in_ready = ~flush & ((r_state == ST_IDLE) | ((r_state == ST_DONE) & out_ready));
    assign w_accept = in_valid & in_ready;
    assign w_last   = (r_cnt == CNT_LAST);

    assign w_imm_sext = {{(WIDTH-17){immediate[16]}}, immediate};
    assign w_use_imm  = (opcode == OP_ADDI) | (opcode == OP_SW) | (opcode == OP_LW);
    assign w_opb      = w_use_imm ? w_imm_sext : ((opcode == OP_BEX) ? {WIDTH{1'b0}} : op_b);
    assign w_eff_op   = w_use_imm ? ALU_ADD : alu_op;
    assign w_is_multi = (opcode == OP_RTYPE) & ((alu_op == ALU_MUL) | (alu_op == ALU_DIV));
    // sw/lw share the add datapath but never flag overflow
    assign w_ovf_en   = (opcode == OP_RTYPE) | (opcode == OP_ADDI);
    assign w_sum      = op_a + w_opb;
    assign w_diff     = op_a - w_opb;
    assign w_mag_a    = op_a[WIDTH-1] ? ({WIDTH{1'b0}} - op_a) : op_a;
    assign w_mag_b    = op_b[WIDTH-1] ? ({WIDTH{1'b0}} - op_b) : op_b;

    // Single-cycle ALU result and signed overflow
    always_comb begin
        w_alu = {WIDTH{1'b0}};
        w_ovf = 1'b0;
        case (w_eff_op)
            ALU_ADD: begin
                w_alu = w_sum;
                w_ovf = w_ovf_en & (op_a[WIDTH-1] == w_opb[WIDTH-1]) & (w_sum[WIDTH-1] != op_a[WIDTH-1]);
            end
            ALU_SUB: begin
                w_alu = w_diff;
                w_ovf = w_ovf_en & (op_a[WIDTH-1] != w_opb[WIDTH-1]) & (w_diff[WIDTH-1] != op_a[WIDTH-1]);
            end
            ALU_AND: w_alu = op_a & w_opb;
            ALU_OR:  w_alu = op_a | w_opb;
            ALU_SLL: w_alu = op_a << shamt;
            ALU_SRA: w_alu = $signed(op_a) >>> shamt;
            default: w_alu = {WIDTH{1'b0}};
        endcase
    end

    assign w_btgt = pc_plus_4 + w_imm_sext;
    assign w_jtgt = {pc_plus_4[WIDTH-1:27], target};

    // Branch / jump resolution
    always_comb begin
        w_take = 1'b0;
        w_pc   = pc_plus_4;
        case (opcode)
            OP_BNE: begin
                if (op_a != op_b) begin
                    w_take = 1'b1;
                    w_pc   = w_btgt;
                end else begin
                    w_take = 1'b0;
                    w_pc   = pc_plus_4;
                end
            end
            OP_BLT: begin
                if ($signed(op_b) < $signed(op_a)) begin
                    w_take = 1'b1;
                    w_pc   = w_btgt;
                end else begin
                    w_take = 1'b0;
                    w_pc   = pc_plus_4;
                end
            end
            OP_BEX: begin
                if (op_a != {WIDTH{1'b0}}) begin
                    w_take = 1'b1;
                    w_pc   = w_jtgt;
                end else begin
                    w_take = 1'b0;
                    w_pc   = pc_plus_4;
                end
            end
            OP_J, OP_JAL: begin
                w_take = 1'b1;
                w_pc   = w_jtgt;
            end
            OP_JR: begin
                w_take = 1'b1;
                w_pc   = op_b;
            end
            default: begin
                w_take = 1'b0;
                w_pc   = pc_plus_4;
            end
        endcase
    end

    // mul adds into the high half then shifts right; div shifts left and
    // keeps the trial difference only when it did not go negative
    assign w_madd  = {1'b0, r_hi[WIDTH-1:0]} + (r_lo[0] ? {1'b0, r_mag_m} : {(WIDTH+1){1'b0}});
    assign w_shift = {r_hi[WIDTH-1:0], r_lo[WIDTH-1]};
    assign w_trial = {1'b0, w_shift} - {2'b00, r_mag_m};

    // One engine iteration
    always_comb begin
        w_hi_nxt = r_hi;
        w_lo_nxt = r_lo;
        if (r_is_div) begin
            if (!w_trial[WIDTH+1]) begin
                w_hi_nxt = w_trial[WIDTH:0];
                w_lo_nxt = {r_lo[WIDTH-2:0], 1'b1};
            end else begin
                w_hi_nxt = w_shift;
                w_lo_nxt = {r_lo[WIDTH-2:0], 1'b0};
            end
        end else begin
            w_hi_nxt = {1'b0, w_madd[WIDTH:1]};
            w_lo_nxt = {w_madd[0], r_lo[WIDTH-1:1]};
        end
    end

    // Final iteration results go straight to the output registers
    assign w_prod_mag = {w_hi_nxt[WIDTH-1:0], w_lo_nxt};
    assign w_prod     = r_neg ? ({(2*WIDTH){1'b0}} - w_prod_mag) : w_prod_mag;
    assign w_mul_ovf  = (w_prod[2*WIDTH-1:WIDTH] != {WIDTH{w_prod[WIDTH-1]}});
    assign w_quo      = r_neg ? ({WIDTH{1'b0}} - w_lo_nxt) : w_lo_nxt;

    // Next-state logic; flush overrides everything
    always_comb begin
        w_state_nxt = r_state;
        if (flush) begin
            w_state_nxt = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) w_state_nxt = w_is_multi ? ST_BUSY : ST_DONE;
                    else          w_state_nxt = ST_IDLE;
                end
                ST_BUSY: begin
                    if (w_last) w_state_nxt = ST_DONE;
                    else        w_state_nxt = ST_BUSY;
                end
                ST_DONE: begin
                    if (w_accept)       w_state_nxt = w_is_multi ? ST_BUSY : ST_DONE;
                    else if (out_ready) w_state_nxt = ST_IDLE;
                    else                w_state_nxt = ST_DONE;
                end
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    // State register and registered out_valid
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= ST_IDLE;
            r_out_valid <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_out_valid <= (w_state_nxt == ST_DONE);
        end
    end

    // Iterative mul/div engine: load on accept, iterate while busy
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt    <= {CNT_W{1'b0}};
            r_is_div <= 1'b0;
            r_neg    <= 1'b0;
            r_b_zero <= 1'b0;
            r_mag_m  <= {WIDTH{1'b0}};
            r_hi     <= {(WIDTH+1){1'b0}};
            r_lo     <= {WIDTH{1'b0}};
        end else if (w_accept && w_is_multi) begin
            r_cnt    <= {CNT_W{1'b0}};
            r_is_div <= (alu_op == ALU_DIV);
            r_neg    <= op_a[WIDTH-1] ^ op_b[WIDTH-1];
            r_b_zero <= (op_b == {WIDTH{1'b0}});
            r_hi     <= {(WIDTH+1){1'b0}};
            r_lo     <= w_mag_b;
            r_mag_m  <= w_mag_a;
            if (alu_op == ALU_DIV) begin
                r_lo    <= w_mag_a;
                r_mag_m <= w_mag_b;
            end
        end else if (r_state == ST_BUSY) begin
            r_cnt <= r_cnt + CNT_ONE;
            r_hi  <= w_hi_nxt;
            r_lo  <= w_lo_nxt;
        end
    end

    // Result registers; held whenever nothing is accepted or completing
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_o_out   <= {WIDTH{1'b0}};
            r_b_out   <= {WIDTH{1'b0}};
            r_rd_out  <= 5'd0;
            r_take    <= 1'b0;
            r_pc_next <= {WIDTH{1'b0}};
            r_ovf     <= 1'b0;
            r_dbz     <= 1'b0;
        end else if (w_accept) begin
            r_b_out   <= op_b;
            r_rd_out  <= rd_in;
            r_take    <= w_take;
            r_pc_next <= w_pc;
            r_dbz     <= 1'b0;
            r_o_out   <= w_is_multi ? {WIDTH{1'b0}} : w_alu;
            r_ovf     <= w_is_multi ? 1'b0 : w_ovf;
        end else if ((r_state == ST_BUSY) && w_last && !flush) begin
            if (r_is_div) begin
                r_o_out <= r_b_zero ? {WIDTH{1'b0}} : w_quo;
                r_ovf   <= 1'b0;
                r_dbz   <= r_b_zero;
            end else begin
                r_o_out <= w_prod[WIDTH-1:0];
                r_ovf   <= w_mul_ovf;
                r_dbz   <= 1'b0;
            end
        end
    end

    assign out_valid   = r_out_valid;
    assign o_out       = r_o_out;
    assign b_out       = r_b_out;
    assign rd_out      = r_rd_out;
    assign take_branch = r_take;
    assign pc_next     = r_pc_next;
    assign overflow    = r_ovf;
    assign div_by_zero = r_dbz;

endmodule

// File: tb/tb_stage_execute_mc.sv
module tb_stage_execute_mc;
    localparam int W = 32;

    logic          clock, reset_n, in_valid, in_ready, flush, out_valid, out_ready;
    logic [4:0]    opcode, alu_op, shamt, rd_in, rd_out;
    logic [16:0]   immediate;
    logic [26:0]   target;
    logic [W-1:0]  op_a, op_b, pc_plus_4, o_out, b_out, pc_next;
    logic          take_branch, overflow, div_by_zero;

    int n_checks = 0;
    int n_pass   = 0;

    stage_execute_mc #(.WIDTH(W)) dut (
        .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
        .opcode(opcode), .alu_op(alu_op), .shamt(shamt), .immediate(immediate),
        .target(target), .rd_in(rd_in), .op_a(op_a), .op_b(op_b), .pc_plus_4(pc_plus_4),
        .flush(flush), .out_valid(out_valid), .out_ready(out_ready), .o_out(o_out),
        .b_out(b_out), .rd_out(rd_out), .take_branch(take_branch), .pc_next(pc_next),
        .overflow(overflow), .div_by_zero(div_by_zero)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [4:0]  opc;
        logic [4:0]  aop;
        logic [4:0]  sh;
        logic [16:0] imm;
        logic [26:0] tgt;
        logic [31:0] a, b, pc;
        logic [31:0] eo;
        logic        eovf, etb;
        logic [31:0] epc;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    task automatic add_vec(input logic [4:0] opc, aop, sh, input logic [16:0] imm,
                           input logic [26:0] tgt, input logic [31:0] a, b, pc, eo,
                           input logic eovf, etb, input logic [31:0] epc);
        vec_t v;
        v.opc = opc; v.aop = aop; v.sh = sh; v.imm = imm; v.tgt = tgt;
        v.a = a; v.b = b; v.pc = pc; v.eo = eo; v.eovf = eovf; v.etb = etb; v.epc = epc;
        vecs.push_back(v);
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Run one mul/div: checks latency, in_ready low while busy, result, optional hold
    task automatic run_multi(input string name, input logic [4:0] aop, input logic [31:0] a, b,
                             input logic [31:0] eo, input logic eovf, edbz, input bit hold);
        int  n;
        bit  ok;
        bit  stable;
        opcode = 5'd0; alu_op = aop; op_a = a; op_b = b; rd_in = 5'd9;
        pc_plus_4 = 32'h0000_0400; in_valid = 1'b1;
        if (hold) out_ready = 1'b0;
        #1;
        check({name, " ready_before"}, 64'(in_ready), 64'd1);
        step();
        in_valid = 1'b0;
        op_b = 32'hDEAD_BEEF;
        n = 0; ok = 1'b1;
        while (!out_valid && n < 100) begin
            if (in_ready) ok = 1'b0;
            step();
            n++;
        end
        check({name, " latency"}, 64'(n), 64'(W));
        check({name, " ready_low_busy"}, 64'(ok), 64'd1);
        check({name, " o_out"}, 64'(o_out), 64'(eo));
        check({name, " overflow"}, 64'(overflow), 64'(eovf));
        check({name, " div_by_zero"}, 64'(div_by_zero), 64'(edbz));
        check({name, " rd_b"}, 64'({rd_out, b_out}), 64'({5'd9, b}));
        check({name, " no_redirect"}, 64'({take_branch, pc_next}), 64'({1'b0, 32'h0000_0400}));
        if (hold) begin
            stable = 1'b1;
            repeat (4) begin
                step();
                if (!out_valid || in_ready || o_out !== eo || div_by_zero !== edbz || rd_out !== 5'd9)
                    stable = 1'b0;
            end
            check({name, " hold_stable"}, 64'(stable), 64'd1);
            out_ready = 1'b1;
        end
        step();
        check({name, " back_idle"}, 64'({out_valid, in_ready}), 64'({1'b0, 1'b1}));
    endtask

    initial begin
        int  n;
        bit  ok;

        reset_n = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
        opcode = 5'd0; alu_op = 5'd0; shamt = 5'd0; immediate = 17'd0; target = 27'd0;
        rd_in = 5'd0; op_a = 32'd0; op_b = 32'd0; pc_plus_4 = 32'd0;

        //        opc      aop      sh     imm         tgt           a             b             pc            exp_o         ovf   tb    exp_pc
        add_vec(5'd0,  5'd0, 5'd0, 17'd0,      27'd0,       32'd7,         32'd5,         32'h100,       32'd12,        1'b0, 1'b0, 32'h100);
        add_vec(5'd0,  5'd1, 5'd0, 17'd0,      27'd0,       32'd7,         32'd5,         32'h100,       32'd2,         1'b0, 1'b0, 32'h100);
        add_vec(5'd0,  5'd0, 5'd0, 17'd0,      27'd0,       32'h7FFFFFFF,  32'd1,         32'h100,       32'h80000000,  1'b1, 1'b0, 32'h100);
        add_vec(5'd0,  5'd2, 5'd0, 17'd0,      27'd0,       32'hF0F0,      32'hFF00,      32'h100,       32'hF000,      1'b0, 1'b0, 32'h100);
        add_vec(5'd0,  5'd3, 5'd0, 17'd0,      27'd0,       32'hF0F0,      32'hFF00,      32'h100,       32'hFFF0,      1'b0, 1'b0, 32'h100);
        add_vec(5'd0,  5'd4, 5'd4, 17'd0,      27'd0,       32'd1,         32'd0,         32'h100,       32'd16,        1'b0, 1'b0, 32'h100);
        add_vec(5'd0,  5'd5, 5'd4, 17'd0,      27'd0,       32'h80000000,  32'd0,         32'h100,       32'hF8000000,  1'b0, 1'b0, 32'h100);
        add_vec(5'd5,  5'd3, 5'd0, 17'h1FFFD,  27'd0,       32'd10,        32'd100,       32'h100,       32'd7,         1'b0, 1'b0, 32'h100);
        add_vec(5'd0,  5'd1, 5'd0, 17'd0,      27'd0,       32'h80000000,  32'd1,         32'h100,       32'h7FFFFFFF,  1'b1, 1'b0, 32'h100);
        add_vec(5'd2,  5'd0, 5'd0, 17'h1FFFC,  27'd0,       32'd3,         32'd4,         32'h100,       32'd7,         1'b0, 1'b1, 32'hFC);
        add_vec(5'd6,  5'd0, 5'd0, 17'd8,      27'd0,       32'hFFFFFFFF,  32'hFFFFFFFE,  32'h200,       32'hFFFFFFFD,  1'b0, 1'b1, 32'h208);
        add_vec(5'd6,  5'd0, 5'd0, 17'd8,      27'd0,       32'hFFFFFFFE,  32'hFFFFFFFF,  32'h200,       32'hFFFFFFFD,  1'b0, 1'b0, 32'h200);
        add_vec(5'd22, 5'd0, 5'd0, 17'd0,      27'h123,     32'd0,         32'd55,        32'h300,       32'd0,         1'b0, 1'b0, 32'h300);
        add_vec(5'd22, 5'd0, 5'd0, 17'd0,      27'h123,     32'd5,         32'd55,        32'h300,       32'd5,         1'b0, 1'b1, 32'h123);
        add_vec(5'd1,  5'd0, 5'd0, 17'd0,      27'h40,      32'd0,         32'd0,         32'hF8000010,  32'd0,         1'b0, 1'b1, 32'hF8000040);
        add_vec(5'd4,  5'd0, 5'd0, 17'd0,      27'd0,       32'd0,         32'h1234,      32'h100,       32'h1234,      1'b0, 1'b1, 32'h1234);
        add_vec(5'd8,  5'd1, 5'd0, 17'h10,     27'd0,       32'h1000,      32'd0,         32'h100,       32'h1010,      1'b0, 1'b0, 32'h100);
        add_vec(5'd2,  5'd0, 5'd0, 17'd0,      27'd0,       32'd9,         32'd9,         32'h100,       32'd18,        1'b0, 1'b0, 32'h100);

        // Reset state
        repeat (3) @(posedge clock);
        #1;
        check("reset_outputs", 64'({out_valid, o_out[7:0], b_out[7:0], rd_out, take_branch, pc_next[7:0], overflow, div_by_zero}), 64'd0);
        check("reset_hi_outputs", 64'({o_out, pc_next}), 64'd0);
        reset_n = 1'b1;
        #1;
        check("reset_in_ready", 64'(in_ready), 64'd1);
        step();

        // Table vectors, issued back to back
        foreach (vecs[i]) begin
            opcode = vecs[i].opc; alu_op = vecs[i].aop; shamt = vecs[i].sh;
            immediate = vecs[i].imm; target = vecs[i].tgt; op_a = vecs[i].a;
            op_b = vecs[i].b; pc_plus_4 = vecs[i].pc; rd_in = 5'(i + 1); in_valid = 1'b1;
            step();
            check($sformatf("vec%0d valid", i), 64'(out_valid), 64'd1);
            check($sformatf("vec%0d o_out", i), 64'(o_out), 64'(vecs[i].eo));
            check($sformatf("vec%0d overflow", i), 64'(overflow), 64'(vecs[i].eovf));
            check($sformatf("vec%0d branch", i), 64'({take_branch, pc_next}), 64'({vecs[i].etb, vecs[i].epc}));
            check($sformatf("vec%0d rd_b", i), 64'({rd_out, b_out}), 64'({5'(i + 1), vecs[i].b}));
        end
        in_valid = 1'b0;
        step();
        check("drain_idle", 64'({out_valid, in_ready}), 64'({1'b0, 1'b1}));

        // Multi-cycle corner cases
        run_multi("mul_ovf",  5'd6, 32'h00010000, 32'h00010000, 32'h0,        1'b1, 1'b0, 1'b0);
        run_multi("mul_neg",  5'd6, 32'hFFFFFFFD, 32'd7,        32'hFFFFFFEB, 1'b0, 1'b0, 1'b0);
        run_multi("mul_nn",   5'd6, 32'hFFFFFFFB, 32'hFFFFFFFA, 32'd30,       1'b0, 1'b0, 1'b0);
        run_multi("div_neg",  5'd7, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 1'b0, 1'b0, 1'b0);
        run_multi("div_pos",  5'd7, 32'd100,      32'd7,        32'd14,       1'b0, 1'b0, 1'b0);
        run_multi("div_zero", 5'd7, 32'd5,        32'd0,        32'd0,        1'b0, 1'b1, 1'b1);

        // Flush on cycle 10 of a divide
        opcode = 5'd0; alu_op = 5'd7; op_a = 32'd1000; op_b = 32'd3; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        repeat (9) step();
        flush = 1'b1;
        #1;
        check("flush_blocks_ready", 64'(in_ready), 64'd0);
        step();
        flush = 1'b0;
        #1;
        check("flush_idle", 64'({out_valid, in_ready}), 64'({1'b0, 1'b1}));
        ok = 1'b1;
        repeat (40) begin
            step();
            if (out_valid) ok = 1'b0;
        end
        check("flush_no_result", 64'(ok), 64'd1);

        // Async reset in the middle of a multiply
        opcode = 5'd0; alu_op = 5'd6; op_a = 32'd7; op_b = 32'd9; rd_in = 5'd17; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        repeat (5) step();
        check("pre_reset_busy", 64'({out_valid, rd_out}), 64'({1'b0, 5'd17}));
        #2;
        reset_n = 1'b0;
        #1;
        check("async_reset_outputs", 64'({out_valid, rd_out, take_branch, overflow, div_by_zero, b_out}), 64'd0);
        check("async_reset_o_pc", 64'({o_out, pc_next}), 64'd0);
        #3;
        reset_n = 1'b1;
        #1;
        check("post_reset_ready", 64'(in_ready), 64'd1);
        n = 0;
        repeat (40) begin
            step();
            if (out_valid) n++;
        end
        check("post_reset_no_result", 64'(n), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
